core_ahbl_arbiter: RTL and testbench

//  Shares one AHB-Lite master port between the Ibex instruction-fetch and LSU req/gnt/rvalid interfaces.

---
 rtl/core_ahbl_arbiter_pkg.sv | 19 +
 rtl/core_ahbl_arbiter_be2size.sv | 33 +++
 rtl/core_ahbl_arbiter.sv | 163 ++++++++++++++++
 tb/tb_core_ahbl_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/core_ahbl_arbiter_pkg.sv
// Shared types and AHB-Lite encodings for the Ibex instruction/LSU to
// single AHB-Lite master arbiter.
package core_ahbl_arbiter_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_DATA, ARB_ERR} arb_state_e;
  typedef enum logic {OWN_INSTR, OWN_DATA} arb_owner_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [3:0] HPROT_FETCH = 4'b0010;
  localparam logic [3:0] HPROT_DATA  = 4'b0011;

  localparam logic [2:0] HSIZE_BYTE    = 3'b000;
  localparam logic [2:0] HSIZE_HALF    = 3'b001;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

endpackage

// File: rtl/core_ahbl_arbiter_be2size.sv
// Byte-enable to AHB transfer size/offset converter.
//   be      in  4  LSU byte enables
//   hsize   out 3  000 one byte, 001 aligned halfword, else 010 word
//   offset  out 2  index of the lowest set byte enable (haddr[1:0])
module ahbl_be2size
  import core_ahbl_arbiter_pkg::*;
(
  input  logic [3:0] be,
  output logic [2:0] hsize,
  output logic [1:0] offset
);

  always_comb begin
    offset = 2'd0;
    casez (be)
      4'b???1: offset = 2'd0;
      4'b??10: offset = 2'd1;
      4'b?100: offset = 2'd2;
      4'b1000: offset = 2'd3;
      default: offset = 2'd0;
    endcase
  end

  always_comb begin
    hsize = HSIZE_WORD;
    case (be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: hsize = HSIZE_BYTE;
      4'b0011, 4'b1100:                   hsize = HSIZE_HALF;
      default:                            hsize = HSIZE_WORD;
    endcase
  end

endmodule

// File: rtl/core_ahbl_arbiter.sv
// Shares one AHB-Lite master port between the Ibex instruction-fetch and LSU
// req/gnt/rvalid interfaces. Address and data phases are pipelined so one
// requester's data phase can overlap the next grant; the two-cycle ERROR
// response cancels any new grant.
// Ports: clk_cpu/rstn_cpu (async active-low); instr_* fetch port; data_* LSU
// port; h* AHB-Lite master signals.
// Build option: define CORE_ARB_RR_EN for round-robin on simultaneous
// requests; otherwise data has fixed priority over instruction fetch.
module core_ahbl_arbiter
  import core_ahbl_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_cpu,
  input  logic                  rstn_cpu,
  input  logic                  instr_req_i,
  input  logic [ADDR_WIDTH-1:0] instr_addr_i,
  output logic                  instr_gnt_o,
  output logic                  instr_rvalid_o,
  output logic [DATA_WIDTH-1:0] instr_rdata_o,
  output logic                  instr_err_o,
  input  logic                  data_req_i,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic [DATA_WIDTH-1:0] data_wdata_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  output logic [DATA_WIDTH-1:0] data_rdata_o,
  output logic                  data_err_o,
  output logic [ADDR_WIDTH-1:0] haddr_o,
  output logic                  hwrite_o,
  output logic [2:0]            hsize_o,
  output logic [2:0]            hburst_o,
  output logic [3:0]            hprot_o,
  output logic [1:0]            htrans_o,
  output logic                  hmastlock_o,
  output logic [DATA_WIDTH-1:0] hwdata_o,
  input  logic [DATA_WIDTH-1:0] hrdata_i,
  input  logic                  hready_i,
  input  logic                  hresp_i
);

  arb_state_e            state, state_next;
  logic                  dp_valid;
  arb_owner_e            dp_owner;
  logic                  dp_write;
  logic [DATA_WIDTH-1:0] dp_wdata;
  logic                  sel_instr, sel_data;
  logic                  grant_ok, grant, done;
  logic [2:0]            be_hsize;
  logic [1:0]            be_offset;
  logic                  unused_addr_lsb;

  assign unused_addr_lsb = ^data_addr_i[1:0];

  ahbl_be2size u_be2size (
    .be     (data_be_i),
    .hsize  (be_hsize),
    .offset (be_offset)
  );

`ifdef CORE_ARB_RR_EN
  arb_owner_e last_owner;

  always_comb begin
    sel_data  = data_req_i;
    sel_instr = instr_req_i;
    if (instr_req_i && data_req_i) begin
      sel_data  = (last_owner == OWN_INSTR);
      sel_instr = (last_owner == OWN_DATA);
    end
  end

  always_ff @(posedge clk_cpu or negedge rstn_cpu) begin
    if (!rstn_cpu)  last_owner <= OWN_INSTR;
    else if (grant) last_owner <= data_gnt_o ? OWN_DATA : OWN_INSTR;
  end
`else
  always_comb begin
    sel_data  = data_req_i;
    sel_instr = instr_req_i & ~data_req_i;
  end
`endif

  // Reset is folded in combinationally so nothing is granted or driven
  // while rstn_cpu is low, even with requests and hready already high.
  assign grant_ok = rstn_cpu & hready_i & (state != ARB_ERR);
  assign grant    = grant_ok & (sel_data | sel_instr);
  assign done     = dp_valid & hready_i;

  always_ff @(posedge clk_cpu or negedge rstn_cpu) begin
    if (!rstn_cpu) state <= ARB_IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ARB_IDLE: if (grant) state_next = ARB_DATA;
      ARB_DATA: begin
        if (hready_i)     state_next = grant ? ARB_DATA : ARB_IDLE;
        else if (hresp_i) state_next = ARB_ERR;
      end
      ARB_ERR:  if (hready_i) state_next = ARB_IDLE;
      default:  state_next = ARB_IDLE;
    endcase
  end

  always_comb begin
    instr_gnt_o    = grant_ok & sel_instr;
    data_gnt_o     = grant_ok & sel_data;
    htrans_o       = grant ? HTRANS_NONSEQ : HTRANS_IDLE;
    instr_rvalid_o = done & (dp_owner == OWN_INSTR);
    data_rvalid_o  = done & (dp_owner == OWN_DATA);
    instr_rdata_o  = (instr_rvalid_o && !dp_write) ? hrdata_i : '0;
    data_rdata_o   = (data_rvalid_o && !dp_write) ? hrdata_i : '0;
    instr_err_o    = instr_rvalid_o & hresp_i;
    data_err_o     = data_rvalid_o & hresp_i;
    hwdata_o       = (dp_valid && dp_write) ? dp_wdata : '0;
  end

  // Address/controls follow the selected requester even while hready is low,
  // so they stay stable over wait states until the grant is finally given.
  always_comb begin
    haddr_o     = '0;
    hwrite_o    = 1'b0;
    hsize_o     = '0;
    hprot_o     = '0;
    hburst_o    = HBURST_SINGLE;
    hmastlock_o = 1'b0;
    if (rstn_cpu) begin
      if (sel_data) begin
        haddr_o  = {data_addr_i[ADDR_WIDTH-1:2], be_offset};
        hwrite_o = data_we_i;
        hsize_o  = be_hsize;
        hprot_o  = HPROT_DATA;
      end else if (sel_instr) begin
        haddr_o  = instr_addr_i;
        hsize_o  = HSIZE_WORD;
        hprot_o  = HPROT_FETCH;
      end
    end
  end

  always_ff @(posedge clk_cpu or negedge rstn_cpu) begin
    if (!rstn_cpu) begin
      dp_valid <= 1'b0;
      dp_owner <= OWN_INSTR;
      dp_write <= 1'b0;
      dp_wdata <= '0;
    end else if (hready_i) begin
      dp_valid <= grant;
      if (grant) begin
        dp_owner <= data_gnt_o ? OWN_DATA : OWN_INSTR;
        dp_write <= data_gnt_o & data_we_i;
        dp_wdata <= (data_gnt_o && data_we_i) ? data_wdata_i : '0;
      end
    end
  end

endmodule

// File: tb/tb_core_ahbl_arbiter.sv
module tb_core_ahbl_arbiter;

  logic        clk_cpu = 1'b0;
  logic        rstn_cpu;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0] instr_rdata_o;
  logic        data_req_i, data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i, data_wdata_i;
  logic        data_gnt_o, data_rvalid_o, data_err_o;
  logic [31:0] data_rdata_o;
  logic [31:0] haddr_o, hwdata_o, hrdata_i;
  logic        hwrite_o, hmastlock_o;
  logic [2:0]  hsize_o, hburst_o;
  logic [3:0]  hprot_o;
  logic [1:0]  htrans_o;
  logic        hready_i, hresp_i;

  int unsigned tests = 0;
  int unsigned fails = 0;
  logic        mon_en = 1'b0;
  logic [31:0] slave_addr = '0;

  always #5 clk_cpu = ~clk_cpu;

  core_ahbl_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_cpu(clk_cpu), .rstn_cpu(rstn_cpu),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .haddr_o(haddr_o), .hwrite_o(hwrite_o), .hsize_o(hsize_o), .hburst_o(hburst_o),
    .hprot_o(hprot_o), .htrans_o(htrans_o), .hmastlock_o(hmastlock_o), .hwdata_o(hwdata_o),
    .hrdata_i(hrdata_i), .hready_i(hready_i), .hresp_i(hresp_i)
  );

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return 32'hA5A5_5A5A ^ {a[31:2], 2'b00} ^ 32'h0000_0100;
  endfunction

  // Slave model: remembers the address of the transfer in its data phase.
  always @(posedge clk_cpu) if (htrans_o == 2'b10 && hready_i) slave_addr <= haddr_o;
  assign hrdata_i = mem_fn(slave_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk_cpu);
    #1;
  endtask

  // Scoreboard: expected completion pushed at grant, popped at rvalid.
  typedef struct {
    logic        owner;  // 1 = data
    logic        write;
    logic [31:0] rdata;
    logic [31:0] wdata;
  } sb_t;
  sb_t  sbq[$];
  sb_t  f;
  sb_t  n;
  logic exp_rv;

  always @(negedge clk_cpu) begin
    if (mon_en) begin
      exp_rv = (sbq.size() > 0) && hready_i;
      f = '{owner: 1'b0, write: 1'b0, rdata: '0, wdata: '0};
      if (sbq.size() > 0) f = sbq[0];
      check("instr_rvalid", 32'(instr_rvalid_o), 32'(exp_rv && !f.owner));
      check("data_rvalid",  32'(data_rvalid_o),  32'(exp_rv && f.owner));
      check("instr_rdata",  instr_rdata_o, (exp_rv && !f.owner) ? f.rdata : '0);
      check("data_rdata",   data_rdata_o,  (exp_rv && f.owner && !f.write) ? f.rdata : '0);
      check("instr_err",    32'(instr_err_o), 32'(exp_rv && !f.owner && hresp_i));
      check("data_err",     32'(data_err_o),  32'(exp_rv && f.owner && hresp_i));
      check("hwdata",       hwdata_o, (sbq.size() > 0 && f.write) ? f.wdata : '0);
      check("one_gnt",      32'(instr_gnt_o & data_gnt_o), 32'd0);
      check("htrans",       32'(htrans_o), (instr_gnt_o | data_gnt_o) ? 32'd2 : 32'd0);
      if (exp_rv) void'(sbq.pop_front());
      if (instr_gnt_o) begin
        n = '{owner: 1'b0, write: 1'b0, rdata: mem_fn(instr_addr_i), wdata: '0};
        sbq.push_back(n);
      end
      if (data_gnt_o) begin
        n = '{owner: 1'b1, write: data_we_i,
              rdata: data_we_i ? 32'd0 : mem_fn(data_addr_i),
              wdata: data_we_i ? data_wdata_i : 32'd0};
        sbq.push_back(n);
      end
    end
  end

  typedef struct {
    logic        ireq, dreq, we;
    logic [3:0]  be;
    logic [31:0] iaddr, daddr, wdata;
    logic        egi, egd;
    logic [31:0] ehaddr;
    logic [2:0]  ehsize;
    logic        ehwrite;
    logic [3:0]  ehprot;
  } vec_t;
  vec_t vecs[9];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            ireq dreq we  be       iaddr         daddr         wdata         egi  egd  haddr         hsize   hwr  hprot
    vecs[0] = '{1'b1, 1'b0, 1'b0, 4'b0000, 32'h0000_1000, 32'h0,        32'h0,        1'b1, 1'b0, 32'h0000_1000, 3'b010, 1'b0, 4'b0010};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 4'b0001, 32'h0,        32'h0000_2000, 32'h0,        1'b0, 1'b1, 32'h0000_2000, 3'b000, 1'b0, 4'b0011};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 4'b0010, 32'h0,        32'h0000_2000, 32'h1111_0002, 1'b0, 1'b1, 32'h0000_2001, 3'b000, 1'b1, 4'b0011};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 4'b1000, 32'h0,        32'h0000_2000, 32'h0,        1'b0, 1'b1, 32'h0000_2003, 3'b000, 1'b0, 4'b0011};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 4'b0011, 32'h0,        32'h0000_2004, 32'h1111_0004, 1'b0, 1'b1, 32'h0000_2004, 3'b001, 1'b1, 4'b0011};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 4'b1100, 32'h0,        32'h0000_2008, 32'h0,        1'b0, 1'b1, 32'h0000_200A, 3'b001, 1'b0, 4'b0011};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 4'b1111, 32'h0,        32'h0000_200C, 32'h1111_0006, 1'b0, 1'b1, 32'h0000_200C, 3'b010, 1'b1, 4'b0011};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 4'b0110, 32'h0,        32'h0000_2010, 32'h0,        1'b0, 1'b1, 32'h0000_2011, 3'b010, 1'b0, 4'b0011};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        3'b000, 1'b0, 4'b0000};

    rstn_cpu = 1'b0; hready_i = 1'b1; hresp_i = 1'b0;
    instr_req_i = 1'b1; instr_addr_i = 32'h0000_0010;
    data_req_i = 1'b1; data_we_i = 1'b0; data_be_i = 4'b1111;
    data_addr_i = 32'h0000_0020; data_wdata_i = 32'h1234_5678;

    // 1. reset with both requests high
    @(negedge clk_cpu);
    check("rst_igntt", 32'(instr_gnt_o), 32'd0);
    check("rst_dgnt",  32'(data_gnt_o),  32'd0);
    check("rst_htrans", 32'(htrans_o),   32'd0);
    check("rst_haddr", haddr_o, 32'd0);
    check("rst_ctrl",  32'({hwrite_o, hsize_o, hburst_o, hprot_o, hmastlock_o}), 32'd0);
    check("rst_rvalid", 32'({instr_rvalid_o, data_rvalid_o, instr_err_o, data_err_o}), 32'd0);
    check("rst_hwdata", hwdata_o, 32'd0);
    cyc();
    rstn_cpu = 1'b1; mon_en = 1'b1;
    @(negedge clk_cpu);
    check("first_dgnt", 32'(data_gnt_o), 32'd1);
    check("first_igntt", 32'(instr_gnt_o), 32'd0);
    cyc(); instr_req_i = 1'b0; data_req_i = 1'b0;
    @(negedge clk_cpu);

    // 2. byte read at 0x102
    cyc(); data_req_i = 1'b1; data_addr_i = 32'h100; data_be_i = 4'b0100;
    @(negedge clk_cpu);
    check("t2_gnt", 32'(data_gnt_o), 32'd1);
    check("t2_haddr", haddr_o, 32'h102);
    check("t2_hsize", 32'(hsize_o), 32'd0);
    check("t2_htrans", 32'(htrans_o), 32'd2);
    cyc(); data_req_i = 1'b0;
    @(negedge clk_cpu);
    check("t2_rvalid", 32'(data_rvalid_o), 32'd1);
    check("t2_rdata", data_rdata_o, 32'hA5A5_5A5A);

    // 3. back-to-back fetches then a write, no bubbles
    cyc(); instr_req_i = 1'b1; instr_addr_i = 32'h0;
    @(negedge clk_cpu); check("t3_g0", 32'(instr_gnt_o), 32'd1);
    cyc(); instr_addr_i = 32'h4;
    @(negedge clk_cpu); check("t3_g1", 32'(instr_gnt_o), 32'd1);
    cyc(); instr_req_i = 1'b0; data_req_i = 1'b1; data_we_i = 1'b1;
    data_addr_i = 32'h200; data_be_i = 4'b1111; data_wdata_i = 32'hDEAD_BEEF;
    @(negedge clk_cpu); check("t3_g2", 32'(data_gnt_o), 32'd1);
    check("t3_hwdata_pre", hwdata_o, 32'd0);
    cyc(); data_req_i = 1'b0; data_we_i = 1'b0;
    @(negedge clk_cpu); check("t3_hwdata", hwdata_o, 32'hDEAD_BEEF);
    check("t3_drv", 32'(data_rvalid_o), 32'd1);
    cyc();
    @(negedge clk_cpu); check("t3_hwdata_post", hwdata_o, 32'd0);

    // 4. three wait states on a fetch data phase
    cyc(); instr_req_i = 1'b1; instr_addr_i = 32'h8;
    @(negedge clk_cpu); check("t4_igntt", 32'(instr_gnt_o), 32'd1);
    cyc(); instr_req_i = 1'b0; data_req_i = 1'b1; data_addr_i = 32'h300; hready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_cpu);
      check("t4_nognt", 32'({instr_gnt_o, data_gnt_o}), 32'd0);
      check("t4_haddr", haddr_o, 32'h300);
      check("t4_irv", 32'(instr_rvalid_o), 32'd0);
      cyc();
    end
    hready_i = 1'b1;
    @(negedge clk_cpu);
    check("t4_irv4", 32'(instr_rvalid_o), 32'd1);
    check("t4_dgnt", 32'(data_gnt_o), 32'd1);
    cyc(); data_req_i = 1'b0;
    @(negedge clk_cpu);

    // 5. two-cycle ERROR on a data read
    cyc(); data_req_i = 1'b1; data_addr_i = 32'h400;
    @(negedge clk_cpu); check("t5_dgnt", 32'(data_gnt_o), 32'd1);
    cyc(); data_req_i = 1'b0; instr_req_i = 1'b1; instr_addr_i = 32'hC; hready_i = 1'b0; hresp_i = 1'b1;
    @(negedge clk_cpu);
    check("t5_nognt1", 32'({instr_gnt_o, data_gnt_o}), 32'd0);
    check("t5_htrans1", 32'(htrans_o), 32'd0);
    check("t5_drv1", 32'(data_rvalid_o), 32'd0);
    cyc(); hready_i = 1'b1;
    @(negedge clk_cpu);
    check("t5_nognt2", 32'({instr_gnt_o, data_gnt_o}), 32'd0);
    check("t5_htrans2", 32'(htrans_o), 32'd0);
    check("t5_derr", 32'({data_err_o, data_rvalid_o, instr_rvalid_o}), 32'b110);
    cyc(); hresp_i = 1'b0;
    @(negedge clk_cpu); check("t5_resume", 32'(instr_gnt_o), 32'd1);
    cyc(); instr_req_i = 1'b0;
    @(negedge clk_cpu);

    // table: address-phase decode, applied back to back
    for (int i = 0; i < 9; i++) begin
      cyc();
      instr_req_i = vecs[i].ireq; data_req_i = vecs[i].dreq; data_we_i = vecs[i].we;
      data_be_i = vecs[i].be; instr_addr_i = vecs[i].iaddr; data_addr_i = vecs[i].daddr;
      data_wdata_i = vecs[i].wdata;
      @(negedge clk_cpu);
      check($sformatf("v%0d_gnt", i), 32'({instr_gnt_o, data_gnt_o}), 32'({vecs[i].egi, vecs[i].egd}));
      check($sformatf("v%0d_haddr", i), haddr_o, vecs[i].ehaddr);
      check($sformatf("v%0d_hsize", i), 32'(hsize_o), 32'(vecs[i].ehsize));
      check($sformatf("v%0d_hwrite", i), 32'(hwrite_o), 32'(vecs[i].ehwrite));
      check($sformatf("v%0d_hprot", i), 32'(hprot_o), 32'(vecs[i].ehprot));
    end

    // 6. both requests held for six grants (last grant before this: instr)
    cyc(); instr_req_i = 1'b1; instr_addr_i = 32'h40;
    @(negedge clk_cpu); check("t6_pre", 32'(instr_gnt_o), 32'd1);
    cyc(); data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h500; data_be_i = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      logic exp_d;
`ifdef CORE_ARB_RR_EN
      exp_d = (k % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      @(negedge clk_cpu);
      check($sformatf("t6_g%0d", k), 32'({instr_gnt_o, data_gnt_o}), 32'({~exp_d, exp_d}));
      cyc();
    end
    instr_req_i = 1'b0; data_req_i = 1'b0;
    @(negedge clk_cpu);
    cyc();
    @(negedge clk_cpu);
    check("sb_drained", 32'(sbq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
